fftbram_line_streamer: RTL and testbench

- FFT-core-side master of the fftbrams port bundle: it drives the FFT_* address, enable and tristate-data signals that fftbrams consumes.
- It turns that bundle into two independent valid/ready streams of 512-bit "lines", where one line is the same address across all 32 BRAMs.
- Port A is the read engine: BRAM to rd stream. Port B is the write engine: wr stream to BRAM.
- It sits between fftbrams and the butterfly datapath, and yields to the MicroBlaze whenever MB_is_acting is high.

---
 rtl/fftbram_line_streamer.sv | 141 ++++++++++++++
 tb/tb_fftbram_line_streamer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fftbram_line_streamer.sv
// fftbram_line_streamer: moves 512-bit BRAM lines between the fftbrams port bundle and
// independent valid/ready read (port A) and write (port B) streams, yielding to the MicroBlaze.
module fftbram_line_streamer #(
    parameter int NBRAM = 32,
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MB_is_acting,
    input  logic                   rd_start,
    input  logic [AW-1:0]          rd_base,
    input  logic [AW:0]            rd_len,
    output logic                   rd_busy,
    output logic                   rd_done,
    output logic [NBRAM*DW-1:0]    rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    input  logic                   wr_start,
    input  logic [AW-1:0]          wr_base,
    input  logic [AW:0]            wr_len,
    output logic                   wr_busy,
    output logic                   wr_done,
    input  logic [NBRAM*DW-1:0]    wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    inout  wire  [NBRAM*DW-1:0]    FFT_dataa,
    inout  wire  [NBRAM*DW-1:0]    FFT_datab,
    output logic [NBRAM*AW-1:0]    FFT_addra,
    output logic [NBRAM*AW-1:0]    FFT_addrb,
    output logic [NBRAM-1:0]       FFT_wea,
    output logic [NBRAM-1:0]       FFT_web,
    output logic [NBRAM-1:0]       FFT_rea,
    output logic [NBRAM-1:0]       FFT_reb
);
    localparam int LW = NBRAM * DW;
    localparam logic [1:0] RD_IDLE = 2'd0, RD_RUN = 2'd1, RD_DRAIN = 2'd2;
    localparam logic [0:0] WR_IDLE = 1'b0, WR_RUN = 1'b1;
    localparam logic [AW-1:0] A1 = 1;
    localparam logic [AW:0] L1 = 1;
    logic [1:0] rd_st;
    logic [AW-1:0] rd_addr;
    logic [AW:0] rd_issue_left, rd_pop_left;
    logic rd_inflight, rd_zero, rd_wp, rd_rp, rd_pop, rd_issue, rd_last_pop;
    logic [1:0] rd_cnt;
    logic [LW-1:0] fifo [2];
    logic [0:0] wr_st;
    logic [AW-1:0] wr_addr;
    logic [AW:0] wr_acc_left, wr_iss_left;
    logic wr_pend_v, wr_done_r, wr_issue, wr_acc;
    logic [LW-1:0] wr_pend;
    assign rd_busy = rd_st != RD_IDLE;
    assign rd_valid = rd_cnt != 2'd0;
    assign rd_data = fifo[rd_rp];
    assign rd_pop = rd_valid && rd_ready;
    // Occupancy after this cycle's pop plus the read already in flight must leave room.
    assign rd_issue = rd_st == RD_RUN && !MB_is_acting && rd_issue_left != '0 &&
                      (rd_cnt - 2'(rd_pop) + 2'(rd_inflight)) < 2'd2;
    assign rd_last_pop = rd_st == RD_DRAIN && rd_pop && rd_pop_left == L1;
    assign rd_done = rd_last_pop || rd_zero;
    assign FFT_rea = {NBRAM{rd_issue}};
    assign FFT_addra = {NBRAM{rd_addr}};
    assign FFT_wea = '0;
    assign FFT_dataa = 'z;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st <= RD_IDLE;
            rd_addr <= '0;
            rd_issue_left <= '0;
            rd_pop_left <= '0;
            rd_inflight <= 1'b0;
            rd_zero <= 1'b0;
            fifo[0] <= '0;
            fifo[1] <= '0;
            rd_wp <= 1'b0;
            rd_rp <= 1'b0;
            rd_cnt <= 2'd0;
        end else begin
            rd_zero <= rd_st == RD_IDLE && rd_start && rd_len == '0;
            rd_inflight <= rd_issue;
            if (rd_inflight) begin
                fifo[rd_wp] <= FFT_dataa;
                rd_wp <= !rd_wp;
            end
            if (rd_pop) begin
                rd_rp <= !rd_rp;
                rd_pop_left <= rd_pop_left - L1;
            end
            rd_cnt <= rd_cnt + 2'(rd_inflight) - 2'(rd_pop);
            if (rd_issue) begin
                rd_addr <= rd_addr + A1;
                rd_issue_left <= rd_issue_left - L1;
            end
            if (rd_st == RD_IDLE && rd_start && rd_len != '0) begin
                rd_st <= RD_RUN;
                rd_addr <= rd_base;
                rd_issue_left <= rd_len;
                rd_pop_left <= rd_len;
            end else if (rd_issue && rd_issue_left == L1) rd_st <= RD_DRAIN;
            else if (rd_last_pop) rd_st <= RD_IDLE;
        end
    end
    assign wr_busy = wr_st == WR_RUN;
    assign wr_issue = wr_pend_v && !MB_is_acting;
    assign wr_ready = wr_busy && wr_acc_left != '0 && (!wr_pend_v || wr_issue);
    assign wr_acc = wr_valid && wr_ready;
    assign wr_done = wr_done_r;
    assign FFT_web = {NBRAM{wr_issue}};
    assign FFT_addrb = {NBRAM{wr_addr}};
    assign FFT_reb = '0;
    // Only drive port B data while writing so the BRAM outputs never see contention.
    assign FFT_datab = wr_issue ? wr_pend : 'z;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_st <= WR_IDLE;
            wr_addr <= '0;
            wr_acc_left <= '0;
            wr_iss_left <= '0;
            wr_pend_v <= 1'b0;
            wr_pend <= '0;
            wr_done_r <= 1'b0;
        end else begin
            wr_done_r <= (wr_st == WR_IDLE && wr_start && wr_len == '0) || (wr_issue && wr_iss_left == L1);
            wr_pend_v <= wr_acc || (wr_pend_v && !wr_issue);
            if (wr_acc) begin
                wr_pend <= wr_data;
                wr_acc_left <= wr_acc_left - L1;
            end
            if (wr_issue) begin
                wr_addr <= wr_addr + A1;
                wr_iss_left <= wr_iss_left - L1;
            end
            if (wr_st == WR_IDLE && wr_start && wr_len != '0) begin
                wr_st <= WR_RUN;
                wr_addr <= wr_base;
                wr_acc_left <= wr_len;
                wr_iss_left <= wr_len;
            end else if (wr_issue && wr_iss_left == L1) wr_st <= WR_IDLE;
        end
    end
endmodule

// File: tb/tb_fftbram_line_streamer.sv
// tb_fftbram_line_streamer: scoreboard bench with a behavioural fftbrams model on both ports.
module tb_fftbram_line_streamer;
    localparam int NBRAM = 32, DW = 16, AW = 9, LW = NBRAM * DW;
    logic clk = 0, rst = 1, MB_is_acting = 0, rd_start = 0, rd_ready = 0, wr_start = 0, wr_valid = 0;
    logic [AW-1:0] rd_base = '0, wr_base = '0;
    logic [AW:0] rd_len = '0, wr_len = '0;
    logic rd_busy, rd_done, rd_valid, wr_busy, wr_done, wr_ready;
    logic [LW-1:0] rd_data, wr_data = '0;
    wire [LW-1:0] FFT_dataa, FFT_datab;
    logic [NBRAM*AW-1:0] FFT_addra, FFT_addrb;
    logic [NBRAM-1:0] FFT_wea, FFT_web, FFT_rea, FFT_reb;
    int errors = 0, checks = 0;

    fftbram_line_streamer #(.NBRAM(NBRAM), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .MB_is_acting(MB_is_acting),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy), .rd_done(rd_done),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_start(wr_start), .wr_base(wr_base), .wr_len(wr_len), .wr_busy(wr_busy), .wr_done(wr_done),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .FFT_dataa(FFT_dataa), .FFT_datab(FFT_datab), .FFT_addra(FFT_addra), .FFT_addrb(FFT_addrb),
        .FFT_wea(FFT_wea), .FFT_web(FFT_web), .FFT_rea(FFT_rea), .FFT_reb(FFT_reb)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] pat(input int a);
        logic [LW-1:0] l;
        for (int b = 0; b < NBRAM; b++) l[b*DW +: DW] = DW'(a + b);
        return l;
    endfunction

    // BRAM model: registered read on port A, write on port B
    bit preload = 1;
    logic [LW-1:0] mem [0:511];
    logic [LW-1:0] qa = '0;
    assign FFT_dataa = qa;
    always @(posedge clk) begin
        if (preload) for (int a = 0; a < 512; a++) mem[a] <= pat(a);
        else begin
            if (FFT_rea[0]) qa <= mem[FFT_addra[AW-1:0]];
            if (FFT_web[0]) mem[FFT_addrb[AW-1:0]] <= FFT_datab;
        end
    end

    logic [LW-1:0] ref_mem [0:511];
    logic [AW-1:0] exp_ra[$], exp_wa[$];
    logic [LW-1:0] exp_rd[$], exp_wd[$], src_q[$];
    int cyc = 0, mb_lo = 1000, mb_hi = -1;
    bit rnd_ready = 0, src_acc = 0;
    logic [31:0] rea_m, val_m, rdone_m, rbusy_m, web_m, wdone_m, wbusy_m;
    bit obs_rea, obs_pop, obs_rdone, obs_wdone;
    logic [AW-1:0] obs_addr;

    // Scoreboard: every issue and every delivered line is checked against the queues
    int occ = 0, infl = 0;
    bit m_pop, m_have;
    logic [AW-1:0] m_a;
    logic [LW-1:0] m_d;
    always @(negedge clk) begin
        if (rst) begin
            occ = 0;
            infl = 0;
        end else begin
            m_pop = rd_valid && rd_ready;
            checks++;
            if (rd_valid !== (occ != 0)) begin
                errors++;
                $display("FAIL rd_valid_occupancy: got %b want %b", rd_valid, occ != 0);
            end
            if (FFT_rea !== '0) begin
                checks++;
                m_have = exp_ra.size() != 0;
                m_a = m_have ? exp_ra.pop_front() : '0;
                if (!m_have || MB_is_acting || FFT_rea !== '1 || FFT_addra !== {NBRAM{m_a}} ||
                    occ - int'(m_pop) + infl >= 2) begin
                    errors++;
                    $display("FAIL read_issue: got addr %0d rea %h mb %b occ %0d infl %0d, want addr %0d (expected=%b)",
                             FFT_addra[AW-1:0], FFT_rea, MB_is_acting, occ, infl, m_a, m_have);
                end
            end
            if (m_pop) begin
                checks++;
                m_have = exp_rd.size() != 0;
                m_d = m_have ? exp_rd.pop_front() : '0;
                if (!m_have || rd_data !== m_d) begin
                    errors++;
                    $display("FAIL read_data: got %h want %h", rd_data, m_d);
                end
            end
            if (FFT_web !== '0) begin
                checks++;
                m_have = exp_wa.size() != 0 && exp_wd.size() != 0;
                m_a = m_have ? exp_wa.pop_front() : '0;
                m_d = m_have ? exp_wd.pop_front() : '0;
                if (!m_have || MB_is_acting || FFT_web !== '1 || FFT_addrb !== {NBRAM{m_a}} || FFT_datab !== m_d) begin
                    errors++;
                    $display("FAIL write_issue: got addr %0d web %h mb %b data %h, want addr %0d data %h",
                             FFT_addrb[AW-1:0], FFT_web, MB_is_acting, FFT_datab, m_a, m_d);
                end
            end
            occ = occ - int'(m_pop) + infl;
            infl = FFT_rea != '0 ? 1 : 0;
        end
    end

    task automatic drive_inputs;
        if (src_acc) void'(src_q.pop_front());
        src_acc = 0;
        wr_valid = src_q.size() > 0;
        wr_data = wr_valid ? src_q[0] : '0;
        if (rnd_ready) rd_ready = 1'($urandom_range(0, 1));
        MB_is_acting = cyc >= mb_lo && cyc <= mb_hi;
    endtask

    task automatic tick;
        @(negedge clk);
        if (cyc >= 0 && cyc < 32) begin
            rea_m[cyc] = |FFT_rea;
            val_m[cyc] = rd_valid;
            rdone_m[cyc] = rd_done;
            rbusy_m[cyc] = rd_busy;
            web_m[cyc] = |FFT_web;
            wdone_m[cyc] = wr_done;
            wbusy_m[cyc] = wr_busy;
        end
        obs_rea = |FFT_rea;
        obs_addr = FFT_addra[AW-1:0];
        obs_pop = rd_valid && rd_ready;
        obs_rdone = rd_done;
        obs_wdone = wr_done;
        src_acc = wr_valid && wr_ready;
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    // Pushes expectations, then pulses the starts so that the sampling edge is E0; returns in cycle 1.
    task automatic launch(input bit r, input logic [AW-1:0] rb, input logic [AW:0] rl,
                          input bit w, input logic [AW-1:0] wb, input logic [AW:0] wl);
        logic [AW-1:0] a;
        logic [LW-1:0] line;
        if (r) for (int i = 0; i < int'(rl); i++) begin
            a = rb + AW'(i);
            exp_ra.push_back(a);
            exp_rd.push_back(ref_mem[a]);
        end
        if (w) for (int i = 0; i < int'(wl); i++) begin
            a = wb + AW'(i);
            for (int b = 0; b < NBRAM; b++) line[b*DW +: DW] = DW'($urandom);
            exp_wa.push_back(a);
            exp_wd.push_back(line);
            src_q.push_back(line);
            ref_mem[a] = line;
        end
        {rea_m, val_m, rdone_m, rbusy_m, web_m, wdone_m, wbusy_m} = '0;
        @(posedge clk);
        #1;
        rd_start = r; rd_base = rb; rd_len = rl;
        wr_start = w; wr_base = wb; wr_len = wl;
        cyc = 0;
        drive_inputs();
        @(posedge clk);
        #1;
        rd_start = 0;
        wr_start = 0;
        cyc = 1;
        drive_inputs();
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_busy, rd_done, rd_valid, wr_busy, wr_done, wr_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000", {rd_busy, rd_done, rd_valid, wr_busy, wr_done, wr_ready});
        end
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++;
        if ({FFT_rea, FFT_web, FFT_wea, FFT_reb} !== '0) begin
            errors++;
            $display("FAIL reset_enables: got %h want 0", {FFT_rea, FFT_web, FFT_wea, FFT_reb});
        end
        checks++;
        if ({FFT_addra, FFT_addrb} !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", {FFT_addra, FFT_addrb}); end
        preload = 0;
        rst = 0;
    endtask

    task automatic test_read_basic;
        rnd_ready = 0;
        rd_ready = 1;
        launch(1, 0, 4, 0, 0, 0);
        repeat (8) tick();
        checks++;
        if (rea_m !== 32'h1E) begin errors++; $display("FAIL basic_rea_cycles: got %h want 1e", rea_m); end
        checks++;
        if (val_m !== 32'h78) begin errors++; $display("FAIL basic_valid_cycles: got %h want 78", val_m); end
        checks++;
        if (rdone_m !== 32'h40) begin errors++; $display("FAIL basic_done_cycle: got %h want 40", rdone_m); end
        checks++;
        if (rbusy_m !== 32'h7E) begin errors++; $display("FAIL basic_busy_cycles: got %h want 7e", rbusy_m); end
    endtask

    task automatic test_reset_mid;
        int pops = 0;
        launch(1, 20, 8, 0, 0, 0);
        for (int i = 0; i < 20 && pops < 3; i++) begin
            tick();
            pops += int'(obs_pop);
        end
        checks++;
        if (pops != 3) begin errors++; $display("FAIL midreset_pops: got %0d want 3", pops); end
        rst = 1;
        #1;
        checks++;
        if ({rd_busy, rd_valid, rd_done, |FFT_rea, |FFT_web, wr_ready} !== 6'b0 || rd_data !== '0 || FFT_addra !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy %b valid %b data %h addr %0d want all 0",
                     rd_busy, rd_valid, rd_data, FFT_addra[AW-1:0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        exp_ra.delete();
        exp_rd.delete();
        launch(1, 40, 2, 0, 0, 0);
        repeat (6) tick();
        checks++;
        if (rea_m !== 32'h6 || val_m !== 32'h18 || rdone_m !== 32'h10) begin
            errors++;
            $display("FAIL after_reset_read: got rea %h valid %h done %h want 6 18 10", rea_m, val_m, rdone_m);
        end
    endtask

    task automatic test_read_wrap;
        bit seen = 0;
        rnd_ready = 1;
        launch(1, 510, 4, 0, 0, 0);
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = obs_rdone;
        end
        rnd_ready = 0;
        rd_ready = 1;
        checks++;
        if (!seen || exp_ra.size() != 0 || exp_rd.size() != 0) begin
            errors++;
            $display("FAIL wrap_complete: got done %b left %0d/%0d want 1 0/0", seen, exp_ra.size(), exp_rd.size());
        end
    endtask

    task automatic test_write_readback;
        launch(0, 0, 0, 1, 100, 3);
        repeat (8) tick();
        checks++;
        if (web_m !== 32'h1C) begin errors++; $display("FAIL write_web_cycles: got %h want 1c", web_m); end
        checks++;
        if (wdone_m !== 32'h20 || wbusy_m !== 32'h1E) begin
            errors++;
            $display("FAIL write_done_busy: got done %h busy %h want 20 1e", wdone_m, wbusy_m);
        end
        launch(1, 100, 3, 0, 0, 0);
        repeat (6) tick();
        checks++;
        if (rdone_m !== 32'h20 || exp_rd.size() != 0 || exp_wd.size() != 0) begin
            errors++;
            $display("FAIL readback: got done %h left %0d want 20 0", rdone_m, exp_rd.size());
        end
    endtask

    task automatic test_mb;
        bit rs = 0, ws = 0;
        mb_lo = 5;
        mb_hi = 9;
        launch(1, 200, 16, 1, 300, 4);
        for (int i = 0; i < 80 && !(rs && ws); i++) begin
            tick();
            rs |= obs_rdone;
            ws |= obs_wdone;
        end
        mb_lo = 1000;
        mb_hi = -1;
        MB_is_acting = 0;
        checks++;
        if (rea_m[4] !== 1'b1) begin errors++; $display("FAIL mb_read_cycle4: got %b want 1", rea_m[4]); end
        checks++;
        if (((rea_m | web_m) & 32'h3E0) !== 32'h0) begin
            errors++;
            $display("FAIL mb_blocked: got rea %h web %h want none in cycles 5..9", rea_m, web_m);
        end
        checks++;
        if (!rs || !ws || exp_rd.size() != 0 || exp_wd.size() != 0) begin
            errors++;
            $display("FAIL mb_complete: got rdone %b wdone %b left %0d/%0d want 1 1 0/0", rs, ws, exp_rd.size(), exp_wd.size());
        end
    endtask

    task automatic test_len_zero;
        launch(1, 5, 0, 1, 6, 0);
        repeat (4) tick();
        checks++;
        if (rdone_m !== 32'h2 || wdone_m !== 32'h2) begin
            errors++;
            $display("FAIL len0_done: got rd %h wr %h want 2 2", rdone_m, wdone_m);
        end
        checks++;
        if ((rea_m | web_m | rbusy_m | wbusy_m) !== 32'h0) begin
            errors++;
            $display("FAIL len0_quiet: got rea %h web %h rbusy %h wbusy %h want 0", rea_m, web_m, rbusy_m, wbusy_m);
        end
    endtask

    task automatic test_len_512;
        int vis [512];
        int bad = 0;
        bit seen = 0;
        foreach (vis[a]) vis[a] = 0;
        launch(1, 7, 10'd512, 0, 0, 0);
        for (int i = 0; i < 700 && !seen; i++) begin
            tick();
            if (obs_rea) vis[obs_addr]++;
            seen = obs_rdone;
        end
        foreach (vis[a]) if (vis[a] != 1) bad++;
        checks++;
        if (!seen || bad != 0) begin errors++; $display("FAIL len512_visits: got done %b bad %0d want 1 0", seen, bad); end
    endtask

    task automatic test_start_while_busy;
        launch(1, 0, 4, 0, 0, 0);
        tick();
        rd_start = 1;
        rd_base = 50;
        rd_len = 2;
        tick();
        rd_start = 0;
        repeat (7) tick();
        checks++;
        if (rea_m !== 32'h1E || rdone_m !== 32'h40 || exp_ra.size() != 0) begin
            errors++;
            $display("FAIL busy_start_ignored: got rea %h done %h want 1e 40", rea_m, rdone_m);
        end
    endtask

    initial begin
        for (int a = 0; a < 512; a++) ref_mem[a] = pat(a);
        test_reset();
        test_read_basic();
        test_reset_mid();
        test_read_wrap();
        test_write_readback();
        test_mb();
        test_len_zero();
        test_len_512();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
